// File: rtl/fmm_column_move_engine_if.sv
// Control and M_e buffer bus of the FMM column-move engine.
// Signals:
//   ap_start/ap_done/ap_idle/ap_ready  block-level handshake
//   move_type, colt, *_base            run configuration (latched on start)
//   M_e_*0                             write-only buffer port 0
//   M_e_*1                             read / clear-write buffer port 1
//   nnz_count                          nonzero elements moved by the last run
// The slave modport is the engine's view; the master modport is the view of
// the controller and the buffer.
interface fmm_column_move_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 32
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [1:0]        move_type;
  logic [CNT_W-1:0]  colt;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst0_base;
  logic [ADDR_W-1:0] dst1_base;
  logic [ADDR_W-1:0] M_e_address0;
  logic              M_e_ce0;
  logic              M_e_we0;
  logic [DATA_W-1:0] M_e_d0;
  logic [ADDR_W-1:0] M_e_address1;
  logic              M_e_ce1;
  logic              M_e_we1;
  logic [DATA_W-1:0] M_e_d1;
  logic [DATA_W-1:0] M_e_q1;
  logic [CNT_W-1:0]  nnz_count;

  modport slave (
    input  ap_start, move_type, colt, src_base, dst0_base, dst1_base, M_e_q1,
    output ap_done, ap_idle, ap_ready,
    output M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
    output M_e_address1, M_e_ce1, M_e_we1, M_e_d1,
    output nnz_count
  );

  modport master (
    output ap_start, move_type, colt, src_base, dst0_base, dst1_base, M_e_q1,
    input  ap_done, ap_idle, ap_ready,
    input  M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
    input  M_e_address1, M_e_ce1, M_e_we1, M_e_d1,
    input  nnz_count
  );
endinterface

// File: rtl/fmm_column_move_engine.sv
// Column-move engine for the FMM reduce kernel.
// For c in 0..colt-1 reads M_e[src_base+c]; a nonzero value v is written to
// M_e[dst0_base+c] and a mode-transformed copy to M_e[dst1_base+c]. Mode 2
// also clears the source element. Two cycles per element.
// Ports:
//   ap_clk    clock
//   ap_rst_n  asynchronous active-low reset
//   bus       engine side (slave) of fmm_column_move_engine_if
//
// state | meaning
// IDLE  | waiting for ap_start, configuration latched on start
// PH_A  | read src_base+c on port1, write pending v2 on port0
// PH_B  | capture read data, write v on port0, optional source clear
// DONE  | one-cycle ap_done/ap_ready pulse
module fmm_column_move_engine #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 17,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input logic ap_clk,
  input logic ap_rst_n,
  fmm_column_move_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [1:0]        mode_r;
  logic [CNT_W-1:0]  colt_r;
  logic [ADDR_W-1:0] src_r, dst0_r, dst1_r;
  logic [CNT_W-1:0]  c;
  logic [ADDR_W-1:0] c_prev;
  logic [CNT_W-1:0]  nnz;
  logic [DATA_W-1:0] v_r;
  logic [DATA_W-1:0] v2;
  logic              pend;
  logic              run_ok;
  logic              c_lt;
  logic              q_nz;

  // colt is signed: positive means the sign bit is clear and it is nonzero
  assign run_ok = !bus.colt[CNT_W-1] && (bus.colt != '0);
  // colt_r is known positive whenever this is used, so unsigned compare works
  assign c_lt   = (c < colt_r);
  assign q_nz   = (bus.M_e_q1 != '0);

  always_comb begin
    v2 = v_r;
    if (mode_r == 2'd0) begin
      if ((SATURATE != 0) && (v_r == MOST_NEG)) v2 = ~MOST_NEG;
      else                                      v2 = -v_r;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ap_start) state_nxt = run_ok ? PH_A : DONE;
      PH_A:    state_nxt = c_lt ? PH_B : DONE;
      PH_B:    state_nxt = PH_A;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ap_idle      = (state == IDLE);
    bus.ap_done      = (state == DONE);
    bus.ap_ready     = (state == DONE);
    bus.M_e_address0 = '0;
    bus.M_e_ce0      = 1'b0;
    bus.M_e_we0      = 1'b0;
    bus.M_e_d0       = '0;
    bus.M_e_address1 = '0;
    bus.M_e_ce1      = 1'b0;
    bus.M_e_we1      = 1'b0;
    bus.M_e_d1       = '0;
    case (state)
      PH_A: begin
        if (c_lt) begin
          bus.M_e_ce1      = 1'b1;
          bus.M_e_address1 = src_r + ADDR_W'(c);
        end
        if (pend) begin
          bus.M_e_ce0      = 1'b1;
          bus.M_e_we0      = 1'b1;
          bus.M_e_address0 = dst1_r + c_prev;
          bus.M_e_d0       = v2;
        end
      end
      PH_B: begin
        if (q_nz) begin
          bus.M_e_ce0      = 1'b1;
          bus.M_e_we0      = 1'b1;
          bus.M_e_address0 = dst0_r + ADDR_W'(c);
          bus.M_e_d0       = bus.M_e_q1;
          if (mode_r == 2'd2) begin
            bus.M_e_ce1      = 1'b1;
            bus.M_e_we1      = 1'b1;
            bus.M_e_address1 = src_r + ADDR_W'(c);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mode_r <= '0;
      colt_r <= '0;
      src_r  <= '0;
      dst0_r <= '0;
      dst1_r <= '0;
      c      <= '0;
      c_prev <= '0;
      nnz    <= '0;
      v_r    <= '0;
      pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          c    <= '0;
          pend <= 1'b0;
          if (bus.ap_start) begin
            mode_r <= bus.move_type;
            colt_r <= bus.colt;
            src_r  <= bus.src_base;
            dst0_r <= bus.dst0_base;
            dst1_r <= bus.dst1_base;
            if (run_ok) nnz <= '0;
          end
        end
        PH_A: pend <= 1'b0;
        PH_B: begin
          v_r    <= bus.M_e_q1;
          pend   <= q_nz;
          c_prev <= ADDR_W'(c);
          c      <= c + 1'b1;
          if (q_nz) nnz <= nnz + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.nnz_count = nnz;

endmodule

// File: tb/tb_fmm_column_move_engine.sv
module tb_fmm_column_move_engine;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  fmm_column_move_engine_if #(.DATA_W(32), .ADDR_W(17), .CNT_W(32)) bus ();
  fmm_column_move_engine_if #(.DATA_W(32), .ADDR_W(17), .CNT_W(32)) bus2 ();

  fmm_column_move_engine #(.DATA_W(32), .ADDR_W(17), .CNT_W(32), .SATURATE(1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));
  fmm_column_move_engine #(.DATA_W(32), .ADDR_W(17), .CNT_W(32), .SATURATE(0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus2));

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_nnz = 0;

  logic [31:0] mem [0:131071];
  logic [31:0] mem2 [0:255];

  always @(posedge ap_clk) begin
    if (bus.M_e_ce1 && !bus.M_e_we1) bus.M_e_q1 <= mem[bus.M_e_address1];
    if (bus.M_e_ce1 && bus.M_e_we1)  mem[bus.M_e_address1] <= bus.M_e_d1;
    if (bus.M_e_ce0 && bus.M_e_we0)  mem[bus.M_e_address0] <= bus.M_e_d0;
    if (bus2.M_e_ce1 && !bus2.M_e_we1) bus2.M_e_q1 <= mem2[bus2.M_e_address1[7:0]];
    if (bus2.M_e_ce1 && bus2.M_e_we1)  mem2[bus2.M_e_address1[7:0]] <= bus2.M_e_d1;
    if (bus2.M_e_ce0 && bus2.M_e_we0)  mem2[bus2.M_e_address0[7:0]] <= bus2.M_e_d0;
  end

  // observed bus activity of the main instance
  logic        mon_en = 1'b0;
  logic [16:0] obs_w_a[$];
  logic [31:0] obs_w_d[$];
  logic [16:0] obs_rd[$];
  logic [16:0] obs_clr_a[$];
  logic [31:0] obs_clr_d[$];
  int          act_cnt = 0;
  int          w0_noe = 0;

  always @(negedge ap_clk) begin
    if (mon_en) begin
      if (bus.M_e_ce0 || bus.M_e_ce1) act_cnt++;
      if (bus.M_e_ce0) begin
        if (!bus.M_e_we0) w0_noe++;
        obs_w_a.push_back(bus.M_e_address0);
        obs_w_d.push_back(bus.M_e_d0);
      end
      if (bus.M_e_ce1 && !bus.M_e_we1) obs_rd.push_back(bus.M_e_address1);
      if (bus.M_e_ce1 && bus.M_e_we1) begin
        obs_clr_a.push_back(bus.M_e_address1);
        obs_clr_d.push_back(bus.M_e_d1);
      end
    end
  end

  function automatic logic [31:0] xform(input logic [1:0] mode, input logic [31:0] v, input bit sat);
    if (mode != 2'd0) return v;
    if (v == 32'h8000_0000) return sat ? 32'h7FFF_FFFF : 32'h8000_0000;
    return -v;
  endfunction

  task automatic run(input logic [1:0] mode, input int colt, input logic [16:0] src,
                     input logic [16:0] d0b, input logic [16:0] d1b);
    logic [16:0] ew_a[$];
    logic [31:0] ew_d[$];
    logic [16:0] er[$];
    logic [16:0] ec[$];
    logic [16:0] a;
    logic [31:0] v;
    logic [31:0] exp_nnz;
    int lat, exp_lat;
    exp_nnz = (colt > 0) ? 0 : last_nnz;
    for (int c = 0; c < colt; c++) begin
      a = src + 17'(c);
      v = mem[a];
      er.push_back(a);
      if (v != 0) begin
        ew_a.push_back(d0b + 17'(c)); ew_d.push_back(v);
        ew_a.push_back(d1b + 17'(c)); ew_d.push_back(xform(mode, v, 1'b1));
        if (mode == 2'd2) ec.push_back(a);
        exp_nnz++;
      end
    end
    exp_lat = (colt > 0) ? 2 * colt + 2 : 1;
    obs_w_a.delete(); obs_w_d.delete(); obs_rd.delete();
    obs_clr_a.delete(); obs_clr_d.delete();
    act_cnt = 0; w0_noe = 0;
    @(negedge ap_clk);
    mon_en = 1'b1;
    bus.move_type = mode; bus.colt = colt; bus.src_base = src;
    bus.dst0_base = d0b; bus.dst1_base = d1b; bus.ap_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge ap_clk);
      if (k == 1) begin
        bus.ap_start = 1'b0;
        bus.move_type = ~mode; bus.colt = colt + 3;
        bus.src_base = 17'($urandom); bus.dst0_base = 17'($urandom); bus.dst1_base = 17'($urandom);
      end
      if (bus.ap_done) begin
        lat = k;
        n_cmp++; if (bus.ap_ready !== 1'b1) begin n_fail++; $display("FAIL ready_with_done: got %b want 1", bus.ap_ready); end
        break;
      end
    end
    n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL latency colt=%0d: got %0d want %0d", colt, lat, exp_lat); end
    @(negedge ap_clk);
    mon_en = 1'b0;
    n_cmp++; if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL done_one_cycle: done=%b idle=%b want 0/1", bus.ap_done, bus.ap_idle); end
    n_cmp++; if (bus.nnz_count !== exp_nnz) begin n_fail++; $display("FAIL nnz_count: got %0d want %0d", bus.nnz_count, exp_nnz); end
    last_nnz = exp_nnz;
    n_cmp++; if (w0_noe != 0) begin n_fail++; $display("FAIL port0_read: got %0d ce0-without-we0 cycles want 0", w0_noe); end
    if (colt <= 0) begin
      n_cmp++; if (act_cnt != 0) begin n_fail++; $display("FAIL no_work_activity: got %0d ce cycles want 0", act_cnt); end
    end
    n_cmp++; if (obs_rd.size() != er.size()) begin n_fail++; $display("FAIL read_count: got %0d want %0d", obs_rd.size(), er.size()); end
    for (int i = 0; i < er.size() && i < obs_rd.size(); i++) begin
      n_cmp++; if (obs_rd[i] !== er[i]) begin n_fail++; $display("FAIL read_addr[%0d]: got %h want %h", i, obs_rd[i], er[i]); end
    end
    n_cmp++; if (obs_w_a.size() != ew_a.size()) begin n_fail++; $display("FAIL write_count: got %0d want %0d", obs_w_a.size(), ew_a.size()); end
    for (int i = 0; i < ew_a.size() && i < obs_w_a.size(); i++) begin
      n_cmp++;
      if (obs_w_a[i] !== ew_a[i] || obs_w_d[i] !== ew_d[i]) begin
        n_fail++; $display("FAIL write[%0d]: got %h=%h want %h=%h", i, obs_w_a[i], obs_w_d[i], ew_a[i], ew_d[i]);
      end
    end
    n_cmp++; if (obs_clr_a.size() != ec.size()) begin n_fail++; $display("FAIL clear_count: got %0d want %0d", obs_clr_a.size(), ec.size()); end
    for (int i = 0; i < ec.size() && i < obs_clr_a.size(); i++) begin
      n_cmp++;
      if (obs_clr_a[i] !== ec[i] || obs_clr_d[i] !== 32'h0) begin
        n_fail++; $display("FAIL clear[%0d]: got %h=%h want %h=0", i, obs_clr_a[i], obs_clr_d[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: idle=%b done=%b ready=%b want 1/0/0", bus.ap_idle, bus.ap_done, bus.ap_ready); end
    n_cmp++; if (bus.M_e_ce0 !== 1'b0 || bus.M_e_ce1 !== 1'b0 || bus.M_e_we0 !== 1'b0 || bus.M_e_we1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem: ce0=%b ce1=%b we0=%b we1=%b want 0", bus.M_e_ce0, bus.M_e_ce1, bus.M_e_we0, bus.M_e_we1); end
    n_cmp++; if (bus.nnz_count !== 32'd0) begin n_fail++; $display("FAIL reset_nnz: got %0d want 0", bus.nnz_count); end
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (bus.ap_idle !== 1'b1 || bus.M_e_ce0 !== 1'b0 || bus.M_e_ce1 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: idle=%b ce0=%b ce1=%b want 1/0/0", bus.ap_idle, bus.M_e_ce0, bus.M_e_ce1); end
  endtask

  task automatic test_copy();
    mem[0] <= 5; mem[1] <= 0; mem[2] <= 7;
    mem[101] <= 32'hDEAD_0101; mem[201] <= 32'hDEAD_0201;
    @(negedge ap_clk);
    run(2'd1, 3, 17'd0, 17'd100, 17'd200);
    n_cmp++; if (mem[100] !== 5 || mem[200] !== 5 || mem[102] !== 7 || mem[202] !== 7) begin
      n_fail++; $display("FAIL copy_data: got %0d %0d %0d %0d want 5 5 7 7", mem[100], mem[200], mem[102], mem[202]); end
    n_cmp++; if (mem[101] !== 32'hDEAD_0101 || mem[201] !== 32'hDEAD_0201) begin
      n_fail++; $display("FAIL copy_untouched: got %h %h want dead0101 dead0201", mem[101], mem[201]); end
    n_cmp++; if (mem[0] !== 5 || mem[2] !== 7) begin n_fail++; $display("FAIL copy_src_kept: got %0d %0d want 5 7", mem[0], mem[2]); end
  endtask

  task automatic test_negate();
    mem[300] <= 32'h8000_0000; mem[301] <= 3;
    @(negedge ap_clk);
    run(2'd0, 2, 17'd300, 17'd400, 17'd500);
    n_cmp++; if (mem[500] !== 32'h7FFF_FFFF || mem[501] !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL negate_sat: got %h %h want 7fffffff fffffffd", mem[500], mem[501]); end
    n_cmp++; if (mem[400] !== 32'h8000_0000 || mem[401] !== 3) begin
      n_fail++; $display("FAIL negate_dst0: got %h %h want 80000000 00000003", mem[400], mem[401]); end
  endtask

  task automatic test_negate_wrap();
    int lat;
    mem2[10] <= 32'h8000_0000; mem2[11] <= 3;
    @(negedge ap_clk);
    bus2.move_type = 2'd0; bus2.colt = 2; bus2.src_base = 17'd10;
    bus2.dst0_base = 17'd20; bus2.dst1_base = 17'd30; bus2.ap_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge ap_clk);
      bus2.ap_start = 1'b0;
      if (bus2.ap_done) begin lat = k; break; end
    end
    n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL wrap_latency: got %0d want 6", lat); end
    @(negedge ap_clk);
    n_cmp++; if (mem2[30] !== 32'h8000_0000 || mem2[31] !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL negate_wrap: got %h %h want 80000000 fffffffd", mem2[30], mem2[31]); end
  endtask

  task automatic test_move_clear();
    mem[600] <= 9; mem[601] <= 4;
    @(negedge ap_clk);
    run(2'd2, 2, 17'd600, 17'd700, 17'd800);
    n_cmp++; if (mem[700] !== 9 || mem[701] !== 4 || mem[800] !== 9 || mem[801] !== 4) begin
      n_fail++; $display("FAIL clear_dst: got %0d %0d %0d %0d want 9 4 9 4", mem[700], mem[701], mem[800], mem[801]); end
    n_cmp++; if (mem[600] !== 0 || mem[601] !== 0) begin
      n_fail++; $display("FAIL clear_src: got %0d %0d want 0 0", mem[600], mem[601]); end
  endtask

  task automatic test_no_work();
    run(2'd1, 0, 17'd0, 17'd900, 17'd950);
    run(2'd2, -5, 17'd0, 17'd900, 17'd950);
    n_cmp++; if (mem[0] !== 5) begin n_fail++; $display("FAIL no_work_src: got %0d want 5", mem[0]); end
  endtask

  task automatic test_addr_wrap();
    mem[17'h1FFFF] <= 11;
    @(negedge ap_clk);
    run(2'd3, 2, 17'h1FFFF, 17'd1000, 17'd1100);
    n_cmp++; if (mem[1000] !== 11 || mem[1001] !== 5 || mem[1101] !== 5) begin
      n_fail++; $display("FAIL addr_wrap: got %0d %0d %0d want 11 5 5", mem[1000], mem[1001], mem[1101]); end
  endtask

  task automatic test_reset_mid_run();
    int seen_done = 0;
    for (int i = 0; i < 4; i++) mem[1200 + i] <= 32'(i + 1);
    @(negedge ap_clk);
    bus.move_type = 2'd1; bus.colt = 4; bus.src_base = 17'd1200;
    bus.dst0_base = 17'd1300; bus.dst1_base = 17'd1400; bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    @(negedge ap_clk);
    n_cmp++; if (bus.M_e_ce0 !== 1'b1) begin n_fail++; $display("FAIL midrun_in_ph_b: ce0=%b want 1", bus.M_e_ce0); end
    ap_rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0 || bus.nnz_count !== 0) begin
      n_fail++; $display("FAIL midrun_reset_ctrl: idle=%b done=%b ready=%b nnz=%0d want 1/0/0/0", bus.ap_idle, bus.ap_done, bus.ap_ready, bus.nnz_count); end
    n_cmp++; if (bus.M_e_ce0 !== 1'b0 || bus.M_e_ce1 !== 1'b0 || bus.M_e_we0 !== 1'b0 || bus.M_e_we1 !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_mem: ce0=%b ce1=%b we0=%b we1=%b want 0", bus.M_e_ce0, bus.M_e_ce1, bus.M_e_we0, bus.M_e_we1); end
    last_nnz = 0;
    @(negedge ap_clk); ap_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge ap_clk);
      if (bus.ap_done) seen_done++;
    end
    n_cmp++; if (seen_done != 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d done pulses want 0", seen_done); end
    n_cmp++; if (mem[1300] !== 0) begin n_fail++; $display("FAIL midrun_no_write: got %0d want 0", mem[1300]); end
    run(2'd1, 4, 17'd1200, 17'd1300, 17'd1400);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        v = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
        if (i == 2) v = 32'h8000_0000;
        mem[2000 + r * 8 + i] <= v;
      end
      @(negedge ap_clk);
      run(2'($urandom_range(0, 3)), 6, 17'(2000 + r * 8), 17'(3000 + r * 8), 17'(4000 + r * 8));
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] <= 32'h0;
    for (int i = 0; i < 256; i++) mem2[i] <= 32'h0;
    bus.ap_start = 1'b0; bus.move_type = 2'd0; bus.colt = 0;
    bus.src_base = 0; bus.dst0_base = 0; bus.dst1_base = 0;
    bus2.ap_start = 1'b0; bus2.move_type = 2'd0; bus2.colt = 0;
    bus2.src_base = 0; bus2.dst0_base = 0; bus2.dst1_base = 0;
    test_reset();
    test_copy();
    test_negate();
    test_negate_wrap();
    test_move_clear();
    test_no_work();
    test_addr_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
